video_cmd_reader: RTL

//  Consumes 64-bit data-mover command words from a command FIFO and executes them.
//  For each command it issues AXI4 read bursts, receives R data and emits it as NASTI-stream beats tagged with dest/user.
//  It is the memory-to-crossbar DMA engine of the video accelerator, and the reader side of the MMIO command path.

---
 rtl/video_cmd_reader.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/video_cmd_reader.sv
// Command-driven AXI4 read DMA: splits each command into 4 KB-safe INCR bursts and streams R data out tagged with dest/user.
// 1-cycle R-to-stream latency; R is throttled by a 2-entry output buffer. VIDEO_CMD_READER_STATS_EN adds stat_cmds/stat_beats.
module video_cmd_reader #(
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int DEST_WIDTH      = 3,
  parameter int USER_WIDTH      = 8,
  parameter int N_DEST          = 1,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [63:0]           cmd_data,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  output logic                  ar_valid,
  input  logic                  ar_ready,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  input  logic                  r_valid,
  output logic                  r_ready,
  output logic [DATA_WIDTH-1:0] s_data,
  output logic [DEST_WIDTH-1:0] s_dest,
  output logic [USER_WIDTH-1:0] s_user,
  output logic                  s_last,
  output logic                  s_valid,
  input  logic                  s_ready,
`ifdef VIDEO_CMD_READER_STATS_EN
  output logic [31:0]           stat_cmds,
  output logic [31:0]           stat_beats,
`endif
  output logic                  busy,
  output logic                  err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int CW    = 22;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW    = DATA_WIDTH + DEST_WIDTH + USER_WIDTH + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [USER_WIDTH-1:0]   user_q;
  logic                    last_q;
  logic [DEST_WIDTH-1:0]   dest_q;
  logic [ADDR_WIDTH-1:0]   next_addr_q;
  logic [CW-1:0]           ar_rem_q;
  logic [CW-1:0]           r_rem_q;
  logic [OW-1:0]           inflight_q;
  logic                    ar_valid_q;
  logic [ADDR_WIDTH-1:0]   ar_addr_q;
  logic [7:0]              ar_len_q;
  logic                    err_q;
  logic [EW-1:0]           mem_q [2];
  logic                    wr_ptr_q, rd_ptr_q;
  logic [1:0]              cnt_q, cnt_d;

  logic                    cmd_acc;
  logic [CW-1:0]           cmd_beats;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DEST_WIDTH-1:0]   cmd_dest;
  logic [12:0]             to_4k;
  logic [CW-1:0]           beats_4k, burst_beats;
  logic                    ar_launch, ar_hs, r_hs, r_last_hs, push, pop, final_beat;
  logic                    unused_ok;

  assign unused_ok = ^{cmd_data[39], cmd_data[5:3]};

  assign cmd_ready = cmd_valid && (state_q == IDLE);
  assign cmd_acc   = cmd_ready;
  assign cmd_beats = CW'({cmd_data[54:40], 6'b0}) >> SZ;
  assign cmd_addr  = ADDR_WIDTH'({cmd_data[38:6], 6'b0});

  always_comb begin
    cmd_dest = '0;
    if ({29'b0, cmd_data[2:0]} < 32'(N_DEST)) cmd_dest = DEST_WIDTH'(cmd_data[2:0]);
  end

  // Burst = min(remaining, MAX_BURST, beats left before the next 4 KB page).
  always_comb begin
    to_4k       = 13'd4096 - {1'b0, next_addr_q[11:0]};
    beats_4k    = CW'(to_4k >> SZ);
    burst_beats = ar_rem_q;
    if (burst_beats > CW'(MAX_BURST)) burst_beats = CW'(MAX_BURST);
    if (burst_beats > beats_4k)       burst_beats = beats_4k;
  end

  assign ar_launch  = (state_q == RUN) && !ar_valid_q && (ar_rem_q != '0) &&
                      (inflight_q < OW'(MAX_OUTSTANDING));
  assign ar_hs      = ar_valid_q && ar_ready;
  assign r_ready    = (cnt_q != 2'd2);
  assign r_hs       = r_valid && r_ready;
  assign r_last_hs  = r_hs && r_last;
  assign push       = r_hs;
  assign pop        = s_valid && s_ready;
  assign final_beat = (state_q == RUN) && r_hs && (r_rem_q == CW'(1));

  assign ar_addr  = ar_addr_q;
  assign ar_len   = ar_len_q;
  assign ar_size  = 3'(SZ);
  assign ar_burst = 2'b01;
  assign ar_valid = ar_valid_q;
  assign busy     = (state_q == RUN);
  assign err      = err_q;
  assign s_valid  = (cnt_q != 2'd0);
  assign {s_data, s_dest, s_user, s_last} = mem_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_acc && (cmd_beats != '0)) state_d = RUN;
      RUN:  if (final_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      user_q      <= '0;
      last_q      <= 1'b0;
      dest_q      <= '0;
      next_addr_q <= '0;
      ar_rem_q    <= '0;
      r_rem_q     <= '0;
      inflight_q  <= '0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (cmd_acc) begin
        user_q      <= cmd_data[63:56];
        last_q      <= cmd_data[55];
        dest_q      <= cmd_dest;
        next_addr_q <= cmd_addr;
        ar_rem_q    <= cmd_beats;
        r_rem_q     <= cmd_beats;
      end
      if (ar_launch) begin
        ar_valid_q  <= 1'b1;
        ar_addr_q   <= next_addr_q;
        ar_len_q    <= 8'(burst_beats - CW'(1));
        next_addr_q <= next_addr_q + (ADDR_WIDTH'(burst_beats) << SZ);
        ar_rem_q    <= ar_rem_q - burst_beats;
      end else if (ar_hs) begin
        ar_valid_q  <= 1'b0;
      end
      case ({ar_hs, r_last_hs})
        2'b10:   inflight_q <= inflight_q + OW'(1);
        2'b01:   if (inflight_q != '0) inflight_q <= inflight_q - OW'(1);
        default: inflight_q <= inflight_q;
      endcase
      if (r_hs && (state_q == RUN)) r_rem_q <= r_rem_q - CW'(1);
      if (r_hs && (r_resp != 2'b00)) err_q <= 1'b1;
    end
  end

  // Each entry carries its own tags so a buffered beat keeps them after the next command is latched.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {r_data, dest_q, user_q,
                            last_q && (state_q == RUN) && (r_rem_q == CW'(1))};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

`ifdef VIDEO_CMD_READER_STATS_EN
  logic [31:0] stat_cmds_q, stat_beats_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      stat_cmds_q  <= '0;
      stat_beats_q <= '0;
    end else begin
      if (final_beat) stat_cmds_q  <= stat_cmds_q + 32'd1;
      if (pop)        stat_beats_q <= stat_beats_q + 32'd1;
    end
  end

  assign stat_cmds  = stat_cmds_q;
  assign stat_beats = stat_beats_q;
`endif

endmodule
